// File: rtl/exe_pkg.sv
// exe_pkg: shared types for the EXE-stage RV32M multiply/divide unit.
// Holds DATA_WIDTH, the funct3 op codes and the mul/div FSM states.
package exe_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_W      = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   function automatic logic is_rem_op(input muldiv_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/exe_muldiv_step.sv
// exe_muldiv_step: one combinational iteration on {acc, mq} -- shift-add
// multiply, or (with RV32M_DIV_EN) restoring shift-subtract divide.
// Ports: is_div (RV32M_DIV_EN only), acc_i/mq_i/opnd_i in, acc_o/mq_o out.
module exe_muldiv_step
   import exe_pkg::*;
(
`ifdef RV32M_DIV_EN
   input  logic                  is_div,
`endif
   input  logic [DATA_WIDTH-1:0] acc_i,
   input  logic [DATA_WIDTH-1:0] mq_i,
   input  logic [DATA_WIDTH-1:0] opnd_i,
   output logic [DATA_WIDTH-1:0] acc_o,
   output logic [DATA_WIDTH-1:0] mq_o
);

   localparam int W = DATA_WIDTH;

   logic [W:0] sum;
`ifdef RV32M_DIV_EN
   logic [W:0] rem_sh;
   logic [W:0] diff;
`endif

   always_comb begin
      // multiply: add multiplicand on mq lsb, then shift {carry,acc,mq} right
      sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = sum[W:1];
      mq_o  = {sum[0], mq_i[W-1:1]};
`ifdef RV32M_DIV_EN
      // divide: shift left, trial subtract; diff msb set means borrow
      rem_sh = {acc_i, mq_i[W-1]};
      diff   = rem_sh - {1'b0, opnd_i};
      if (is_div) begin
         acc_o = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
         mq_o  = {mq_i[W-2:0], ~diff[W]};
      end
`endif
   end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: iterative RV32M unit for the EXE stage; stalls the pipe
// while busy. Ports: clk, rst (async, active-low), start/op/rs1_data/
// rs2_data/flush in; stall_o, done_o, result_o out.
// Divider present only when RV32M_DIV_EN is defined.
module exe_muldiv_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  flush,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   import exe_pkg::*;

   localparam int W = DATA_WIDTH;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);
`ifdef RV32M_DIV_EN
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

   muldiv_state_e state_q, state_d;
   muldiv_op_e    op_q, op_d, op_in;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] mq_q, mq_d;
   logic [W-1:0] opnd_q, opnd_d;
   logic [W-1:0] res_q, res_d;
   logic         neg_q, neg_d;

   logic         a_sgn, b_sgn, a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;
   logic [W-1:0] cap_acc, cap_mq, cap_opnd;
   logic         cap_neg, cap_skip;
   logic [W-1:0] step_acc, step_mq;
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0] fixed;
   logic         accept;

   exe_muldiv_step u_step (
`ifdef RV32M_DIV_EN
      .is_div (op_q[2]),
`endif
      .acc_i  (acc_q),
      .mq_i   (mq_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc),
      .mq_o   (step_mq)
   );

   // operand capture: magnitudes, result sign, early-out cases
   always_comb begin
      op_in = muldiv_op_e'(op);
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (op_in)
         OP_MULH, OP_DIV, OP_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         OP_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
      a_neg    = a_sgn & rs1_data[W-1];
      b_neg    = b_sgn & rs2_data[W-1];
      a_mag    = a_neg ? -rs1_data : rs1_data;
      b_mag    = b_neg ? -rs2_data : rs2_data;
      cap_acc  = '0;
      cap_mq   = op[2] ? a_mag : b_mag;
      cap_opnd = op[2] ? b_mag : a_mag;
      cap_neg  = is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
      cap_skip = 1'b0;
`ifdef RV32M_DIV_EN
      // raw results parked in acc (rem) / mq (quot), no sign fix-up
      if (op[2] && rs2_data == '0) begin
         cap_acc  = rs1_data;
         cap_mq   = '1;
         cap_neg  = 1'b0;
         cap_skip = 1'b1;
      end else if (op[2] && b_sgn && rs1_data == MIN_NEG
                   && rs2_data == '1) begin
         cap_mq   = MIN_NEG;
         cap_neg  = 1'b0;
         cap_skip = 1'b1;
      end
`else
      if (op[2]) begin
         cap_mq   = '0;
         cap_neg  = 1'b0;
         cap_skip = 1'b1;
      end
`endif
   end

   // sign fix-up and result select, used only in DONE
   always_comb begin
      prod     = {acc_q, mq_q};
      prod_fix = neg_q ? -prod : prod;
      fixed    = '0;
      unique case (op_q)
         OP_MUL: fixed = prod_fix[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod_fix[2*W-1:W];
`ifdef RV32M_DIV_EN
         OP_DIV, OP_DIVU: fixed = neg_q ? -mq_q : mq_q;
         OP_REM, OP_REMU: fixed = neg_q ? -acc_q : acc_q;
`endif
         default: fixed = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      res_d   = res_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
      accept  = start & ~flush;
      unique case (state_q)
         IDLE: stall_o = accept;
         CALC: begin
            stall_o = 1'b1;
            acc_d   = step_acc;
            mq_d    = step_mq;
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            done_o  = ~flush;
            state_d = IDLE;
            if (!flush) begin
               res_d = fixed;
            end
         end
         default: state_d = IDLE;
      endcase
      // new op accepted from IDLE or back-to-back from DONE
      if (accept && state_q != CALC) begin
         op_d    = op_in;
         cnt_d   = CNT_LOAD;
         acc_d   = cap_acc;
         mq_d    = cap_mq;
         opnd_d  = cap_opnd;
         neg_d   = cap_neg;
         state_d = cap_skip ? DONE : CALC;
      end
      if (flush) begin
         state_d = IDLE;
      end
      // keep stall low while reset is asserted, even with start high
      stall_o = stall_o & rst;
   end

   assign result_o = done_o ? fixed : res_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_MUL;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         opnd_q  <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         opnd_q  <= opnd_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb_exe_muldiv_ctrl: directed and random checks of exe_muldiv_ctrl
// against an arithmetic reference model (honours RV32M_DIV_EN).
module tb_exe_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        stall_o, done_o;
   logic [31:0] result_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] last_res = '0;
   logic [31:0] obs_res;

`ifdef RV32M_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   exe_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb, sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o[2] && !DIV_EN) return 32'h0;
      case (o)
         3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * longint'({32'h0, b}); return sp[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            sp = sa / sb;
            return sp[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            sp = sa % sb;
            return sp[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      if (!o[2]) return 33;
      if (!DIV_EN) return 1;
      if (b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000
          && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // one op from IDLE: checks latency, stall cycles, result, pulse width
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
      int lat, nst, exp_lat;
      logic [31:0] r, exp_r;
      exp_lat = ref_lat(o, a, b);
      exp_r   = ref_res(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; rs1_data = a; rs2_data = b;
      #1 chk({tag, "_stall0"}, stall_o, 1'b1);
      lat = -1;
      nst = 0;
      r   = 'x;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (done_o === 1'b1) begin
            lat = c;
            r   = result_o;
            chk({tag, "_stall_done"}, stall_o, 1'b0);
         end else if (stall_o === 1'b1) begin
            nst++;
         end
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_stallcnt"}, 64'(nst), 64'(exp_lat - 1));
      chk({tag, "_res"}, r, exp_r);
      @(negedge clk);
      #1;
      chk({tag, "_pulse"}, done_o, 1'b0);
      chk({tag, "_hold"}, result_o, exp_r);
      obs_res  = r;
      last_res = exp_r;
   endtask

   initial begin
      int d1, d2, nd;
      logic [31:0] r1, r2, ra, rb;
      logic [2:0]  ro;

      // reset with start high: everything low
      start = 1'b1;
      #12;
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_res", result_o, 32'h0);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;

      run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
      chk("mul_7x-3_const", obs_res, 32'hFFFF_FFEB);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulhu_max_const", obs_res, 32'hFFFF_FFFE);
      run_op("mulh_neg", 3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
`ifdef RV32M_DIV_EN
      run_op("div_-7_2b", 3'd4, 32'hFFFF_FFF9, 32'd2);
      chk("div_-7_2_const", obs_res, 32'hFFFF_FFFD);
      run_op("rem_-7_2b", 3'd6, 32'hFFFF_FFF9, 32'd2);
      chk("rem_-7_2_const", obs_res, 32'hFFFF_FFFF);
`else
      run_op("div_9_3_nodiv", 3'd4, 32'd9, 32'd3);
      chk("div_9_3_const", obs_res, 32'h0);
`endif
      run_op("divu_5_0", 3'd5, 32'd5, 32'd0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("remu_0", 3'd7, 32'h1234_5678, 32'd0);
      run_op("mul_seed", 3'd0, 32'd11, 32'd13);

      // start together with flush: not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'd0; rs1_data = 5; rs2_data = 6;
      #1 chk("flush_start_stall", stall_o, 1'b0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 chk("flush_start_idle", stall_o, 1'b0);

      // flush in CALC cycle 10
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs1_data = 3; rs2_data = 4;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (c == 10);
      end
      #1 chk("flush_calc_stall", stall_o, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("flush_idle_stall", stall_o, 1'b0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1 if (done_o === 1'b1) nd++;
      end
      chk("flush_no_done", 64'(nd), 64'd0);
      chk("flush_res_kept", result_o, last_res);

      // back-to-back: start held through CALC and DONE
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs1_data = 32'h1234; rs2_data = 32'h10;
      d1 = -1;
      r1 = 'x;
      for (int c = 1; c <= 40 && d1 < 0; c++) begin
         @(negedge clk);
         op = 3'd0; rs1_data = 2; rs2_data = 3;
         #1 if (done_o === 1'b1) begin
            d1 = c;
            r1 = result_o;
         end
      end
      d2 = -1;
      r2 = 'x;
      for (int c = 1; c <= 40 && d2 < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1 if (done_o === 1'b1) begin
            d2 = c;
            r2 = result_o;
         end
      end
      start = 1'b0;
      chk("b2b_lat1", 64'(d1), 64'd33);
      chk("b2b_res1", r1, ref_res(3'd0, 32'h1234, 32'h10));
      chk("b2b_gap", 64'(d2), 64'd33);
      chk("b2b_res2", r2, 32'd6);

      // reset mid-CALC
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs1_data = 32'hFFFF; rs2_data = 32'hFFFF;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 chk("rstmid_busy", stall_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_stall", stall_o, 1'b0);
      chk("rstmid_done", done_o, 1'b0);
      chk("rstmid_res", result_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      last_res = '0;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1 if (done_o === 1'b1) nd++;
      end
      chk("rstmid_no_done", 64'(nd), 64'd0);

      // random ops against the reference model
      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            default: ;
         endcase
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
